// File: rtl/spi_fifo_tx_pkg.sv
// spi_fifo_tx_pkg: shared FSM states, active-low FIFO flag levels and SPI mode constants
// Build option: SPI_TX_LSB_FIRST_EN selects LSB-first shifting (default MSB first).
package spi_fifo_tx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP_HI = 3'd1,
    POP_LO = 3'd2,
    WAIT_D = 3'd3,
    LOAD   = 3'd4,
    SHIFT  = 3'd5,
    HOLD   = 3'd6
  } state_e;
  localparam logic FLAG_TRUE  = 1'b0;
  localparam logic FLAG_FALSE = ~FLAG_TRUE;
  localparam logic SPI_CPOL   = 1'b0;
`ifdef SPI_TX_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: HALF_DIV cycle divider giving a 1-cycle phase_tick and a half-period phase bit
// Ports: clk, rst (async active-low), clr (hold cleared), phase_tick (last cycle of a half), phase (0 low half, 1 high half)
module spi_clk_div #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic phase_tick,
  output logic phase
);
  localparam int HW = $clog2(HALF_DIV);
  logic [HW-1:0] div_q, div_d;
  logic phase_q, phase_d;
  assign phase_tick = !clr && div_q == HW'(HALF_DIV - 1);
  assign phase = phase_q;
  always_comb begin
    div_d   = (clr || phase_tick) ? '0 : div_q + 1'b1;
    phase_d = clr ? 1'b0 : phase_q ^ phase_tick;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/spi_fifo_tx.sv
// spi_fifo_tx: drains a FIFO with edge-triggered pops and serializes bytes as an SPI mode-0 master
// Ports: clk, rst (async active-low), enable, fifo_empty (active-low, 0 = empty), fifo_odat,
//        fifo_oen (pop on 1->0), spi_sclk, spi_mosi, spi_cs_n, busy, byte_cnt (wrapping byte count)
// Build option: SPI_TX_LSB_FIRST_EN shifts LSB first; timing is unchanged.
module spi_fifo_tx
  import spi_fifo_tx_pkg::*;
#(
  parameter int DW       = 8,
  parameter int HALF_DIV = 4,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_odat,
  output logic          fifo_oen,
  output logic          spi_sclk,
  output logic          spi_mosi,
  output logic          spi_cs_n,
  output logic          busy,
  output logic [CW-1:0] byte_cnt
);
  localparam int BW = $clog2(DW);
  localparam int HW = $clog2(HALF_DIV);
  state_e state_q, state_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic oen_q, oen_d, mosi_q, mosi_d, cs_n_q, cs_n_d, busy_q, busy_d;
  logic tick, phase, go, bit_end, byte_end;
  spi_clk_div #(.HALF_DIV(HALF_DIV)) u_div (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_q != SHIFT),
    .phase_tick (tick),
    .phase      (phase)
  );
  // a new byte may start only while the FIFO reports data
  assign go       = enable && fifo_empty == FLAG_FALSE;
  assign bit_end  = state_q == SHIFT && tick && phase;
  assign byte_end = bit_end && bit_q == BW'(DW - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? POP_HI : IDLE;
      POP_HI:  state_d = POP_LO;
      POP_LO:  state_d = WAIT_D;
      WAIT_D:  state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   state_d = byte_end ? (go ? POP_HI : HOLD) : SHIFT;
      HOLD:    state_d = hold_q == HW'(HALF_DIV - 1) ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
    sh_d   = state_q == LOAD ? fifo_odat : bit_end ? (LSB_FIRST ? sh_q >> 1 : sh_q << 1) : sh_q;
    // mosi moves only as a low half begins: at load, and after each non-final high half
    mosi_d = (state_q == LOAD || (bit_end && !byte_end)) ? (LSB_FIRST ? sh_d[0] : sh_d[DW-1]) : mosi_q;
    bit_d  = state_q == LOAD ? '0 : bit_end ? bit_q + 1'b1 : bit_q;
    hold_d = state_q == HOLD ? hold_q + 1'b1 : '0;
    cnt_d  = cnt_q + CW'(byte_end);
    oen_d  = state_d == POP_HI;
    cs_n_d = state_d == IDLE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      oen_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      oen_q   <= oen_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
    end
  end
  assign fifo_oen = oen_q;
  assign spi_sclk = phase ^ SPI_CPOL;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = busy_q;
  assign byte_cnt = cnt_q;
endmodule

// File: tb/tb_spi_fifo_tx.sv
// tb_spi_fifo_tx: FIFO agent plus SPI decoder scoreboard with directed and random stimulus
module tb_spi_fifo_tx;
  localparam int DW = 8;
  localparam int H  = 4;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst, enable, fifo_empty, fifo_oen, spi_sclk, spi_mosi, spi_cs_n, busy;
  logic [DW-1:0] fifo_odat;
  logic [CW-1:0] byte_cnt;
  int total = 0, passed = 0;
  int bits = 0, cs_rises = 0, pops = 0, n_rand = 0;
  logic [DW-1:0] seq = '0, last_seq = '0;
  logic [CW-1:0] exp_cnt = '0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];

  spi_fifo_tx #(.DW(DW), .HALF_DIV(H), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_odat  (fifo_odat),
    .fifo_oen   (fifo_oen),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .busy       (busy),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // FIFO that pops on the falling edge of fifo_oen; popped bytes become the expected SPI stream
  task automatic agent();
    logic oen_prev = 1'b0;
    logic [DW-1:0] d;
    forever begin
      @(posedge clk);
      if (oen_prev && !fifo_oen) begin
        chk("pop_nonempty", 32'(fq.size() != 0), 32'd1);
        if (fq.size() != 0) begin
          d = fq.pop_front();
          fifo_odat <= d;
          exp_q.push_back(d);
          pops++;
        end
      end
      oen_prev = fifo_oen;
      fifo_empty <= fq.size() != 0;
    end
  endtask

  // decodes the SPI pins each cycle and checks framing, half-periods and data
  task automatic monitor();
    logic p_sclk = 1'b0, p_cs = 1'b1, p_oen = 1'b0, p_mosi = 1'b0;
    int run = 0, oen_run = 0, since_fall = 0;
    logic [DW-1:0] dec;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        bits = 0; exp_cnt = '0; run = 0; oen_run = 0;
        p_sclk = 1'b0; p_cs = 1'b1; p_oen = 1'b0; p_mosi = 1'b0;
        continue;
      end
      since_fall++;
      chk("busy_vs_cs", 32'(busy), 32'(!spi_cs_n));
      if (spi_cs_n) chk("sclk_idle", 32'(spi_sclk), 32'd0);
      if (fifo_oen) oen_run++;
      else if (p_oen) begin
        chk("oen_width", 32'(oen_run), 32'd1);
        oen_run = 0;
      end
      if (spi_sclk && !p_sclk) begin
        if (bits > 0) chk("low_half", 32'(run), 32'(H));
        bits++;
        seq = {seq[DW-2:0], spi_mosi};
        run = 1;
      end else if (!spi_sclk && p_sclk) begin
        chk("high_half", 32'(run), 32'(H));
        run = 1;
        if (bits == DW) begin
          dec = seq;
`ifdef SPI_TX_LSB_FIRST_EN
          for (int i = 0; i < DW; i++) dec[i] = seq[DW-1-i];
`endif
          if (exp_q.size() == 0) chk("byte_expected", 32'd0, 32'd1);
          else chk("byte_data", 32'(dec), 32'(exp_q.pop_front()));
          exp_cnt++;
          last_seq = seq;
          bits = 0;
          since_fall = 0;
        end
      end else run++;
      if (spi_sclk && p_sclk) chk("mosi_stable", 32'(spi_mosi), 32'(p_mosi));
      chk("byte_cnt", 32'(byte_cnt), 32'(exp_cnt));
      if (spi_cs_n && !p_cs) begin
        cs_rises++;
        chk("cs_hold", 32'(since_fall), 32'(H));
        chk("no_partial", 32'(bits), 32'd0);
      end
      p_sclk = spi_sclk; p_cs = spi_cs_n; p_oen = fifo_oen; p_mosi = spi_mosi;
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fq.push_back(d);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int ok = 0;
    for (int i = 0; i < max && ok < 4; i++) begin
      cyc();
      ok = (!busy && (fq.size() == 0 || !enable)) ? ok + 1 : 0;
    end
    chk("idle_reached", 32'(ok >= 4), 32'd1);
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 2000 && bits != n; i++) cyc();
    chk("bits_reached", 32'(bits == n), 32'd1);
  endtask

  initial begin
    int r0, bad;
    rst = 1'b1; enable = 1'b0; fifo_empty = 1'b0; fifo_odat = '0;
    #1 rst = 1'b0;
    fork
      monitor();
      agent();
    join_none
    #1;
    chk("rst_oen", 32'(fifo_oen), 32'd0);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    repeat (3) cyc();
    rst = 1'b1;
    // single byte 0xA5
    push(8'hA5); enable = 1'b1;
    wait_idle(400);
    chk("t1_seq", 32'(last_seq), 32'hA5);
    chk("t1_cnt", 32'(byte_cnt), 32'd1);
    chk("t1_pops", 32'(pops), 32'd1);
    chk("t1_cs_n", 32'(spi_cs_n), 32'd1);
    // three back-to-back bytes in one cs frame
    r0 = cs_rises;
    push(8'h01); push(8'h80); push(8'hFF);
    wait_idle(800);
    chk("t2_cnt", 32'(byte_cnt), 32'd4);
    chk("t2_pops", 32'(pops), 32'd4);
    chk("t2_frames", 32'(cs_rises - r0), 32'd1);
    chk("t2_fifo_empty", 32'(fq.size()), 32'd0);
    // empty FIFO stays quiet
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (!spi_cs_n || fifo_oen || busy) bad++;
    end
    chk("t3_quiet", 32'(bad), 32'd0);
    // enable dropped mid-byte
    push(8'h3C); push(8'hC3);
    wait_bits(3);
    enable = 1'b0;
    wait_idle(400);
    chk("t4_level", 32'(fq.size()), 32'd1);
    chk("t4_cnt", 32'(byte_cnt), 32'd5);
    chk("t4_seq", 32'(last_seq), 32'h3C);
    chk("t4_cs_n", 32'(spi_cs_n), 32'd1);
    // reset mid-byte drops 0xC3, then 0x99 goes out intact
    enable = 1'b1;
    wait_bits(5);
    rst = 1'b0;
    #1;
    chk("t5_sclk", 32'(spi_sclk), 32'd0);
    chk("t5_cs_n", 32'(spi_cs_n), 32'd1);
    chk("t5_oen", 32'(fifo_oen), 32'd0);
    chk("t5_cnt", 32'(byte_cnt), 32'd0);
    push(8'h99);
    repeat (2) cyc();
    rst = 1'b1;
    wait_idle(400);
    chk("t5_seq", 32'(last_seq), 32'h99);
    chk("t5_cnt_after", 32'(byte_cnt), 32'd1);
    // bit order
    push(8'h0F);
    wait_idle(400);
`ifdef SPI_TX_LSB_FIRST_EN
    chk("t6_seq", 32'(last_seq), 32'hF0);
`else
    chk("t6_seq", 32'(last_seq), 32'h0F);
`endif
    chk("t6_cnt", 32'(byte_cnt), 32'd2);
    // random pushes and enable toggles
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(5) == 0 && fq.size() < 6) begin
        push(DW'($urandom));
        n_rand++;
      end
      if ($urandom_range(49) == 0) enable = !enable;
    end
    enable = 1'b1;
    wait_idle(6000);
    chk("rand_exp_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_fifo_drained", 32'(fq.size()), 32'd0);
    chk("rand_cnt", 32'(byte_cnt), 32'(CW'(2 + n_rand)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
